// File: rtl/conv3x3_ctrl_pkg.sv
// Shared types and sizing for the 3x3 convolution sequencing controller.
package conv3x3_ctrl_pkg;

    localparam int unsigned TAPS_C = 9;
    localparam int unsigned LAT_C  = 27;

    // Counter width able to hold the value lat (0..lat inclusive).
    function automatic int unsigned lat_w(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

    localparam int unsigned IDX_W = $clog2(TAPS_C);
    localparam int unsigned LAT_W = lat_w(LAT_C);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/conv3x3_ctrl_if.sv
// Feeder, datapath and result signals of the convolution controller.
interface conv3x3_ctrl_if #(
    parameter int unsigned X_BW = 8,
    parameter int unsigned W_BW = 8,
    parameter int unsigned I_BW = 19,
    parameter int unsigned O_BW = 19
) ();

    logic                   i_clear;
    logic                   i_start;
    logic signed [I_BW-1:0] i_psum;
    logic signed [X_BW-1:0] i_x;
    logic signed [W_BW-1:0] i_w;
    logic                   i_xw_valid;
    logic                   o_xw_ready;
    logic signed [X_BW-1:0] o_dp_x;
    logic signed [W_BW-1:0] o_dp_w;
    logic signed [I_BW-1:0] o_dp_psum;
    logic signed [O_BW-1:0] i_dp_y;
    logic signed [O_BW-1:0] o_y;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_busy;

    // Controller side.
    modport slave (
        input  i_clear, i_start, i_psum, i_x, i_w, i_xw_valid, i_dp_y, i_ready,
        output o_xw_ready, o_dp_x, o_dp_w, o_dp_psum, o_y, o_valid, o_busy
    );

    // Environment side: feeder, datapath and result consumer.
    modport master (
        output i_clear, i_start, i_psum, i_x, i_w, i_xw_valid, i_dp_y, i_ready,
        input  o_xw_ready, o_dp_x, o_dp_w, o_dp_psum, o_y, o_valid, o_busy
    );

endinterface

// File: rtl/conv3x3_tap_buf.sv
// Nine-entry {x, w} register file: one write port, one combinational read port.
module conv3x3_tap_buf
    import conv3x3_ctrl_pkg::*;
#(
    parameter int unsigned X_BW = 8,
    parameter int unsigned W_BW = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic signed [X_BW-1:0] wr_x_i,
    input  logic signed [W_BW-1:0] wr_w_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic signed [X_BW-1:0] rd_x_o,
    output logic signed [W_BW-1:0] rd_w_o
);

    logic signed [X_BW-1:0] x_q [TAPS_C];
    logic signed [W_BW-1:0] w_q [TAPS_C];

    // Store one accepted tap pair at the write index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAPS_C; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            x_q[wr_idx_i] <= wr_x_i;
            w_q[wr_idx_i] <= wr_w_i;
        end
    end

    assign rd_x_o = x_q[rd_idx_i];
    assign rd_w_o = w_q[rd_idx_i];

endmodule

// File: rtl/conv3x3_ctrl.sv
// Sequencer: buffers a 3x3 window, replays it gap-free to the MAC datapath,
// waits out the pipeline latency and presents the result on valid/ready.
module conv3x3_ctrl
    import conv3x3_ctrl_pkg::*;
#(
    parameter int unsigned X_BW = 8,
    parameter int unsigned W_BW = 8,
    parameter int unsigned I_BW = 19,
    parameter int unsigned O_BW = 19,
    parameter int unsigned TAPS = TAPS_C,
    parameter int unsigned LAT  = LAT_C
) (
    input  logic           i_clk,
    input  logic           i_rst,
    conv3x3_ctrl_if.slave  bus
);

    localparam int unsigned      CntW    = lat_w(LAT);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TAPS - 1);
    localparam logic [CntW-1:0]  LastLat = CntW'(LAT - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       wr_idx_q;
    logic [IDX_W-1:0]       rd_idx_q;
    logic [CntW-1:0]        lat_q;
    logic signed [I_BW-1:0] psum_q;
    logic signed [X_BW-1:0] dp_x_q;
    logic signed [W_BW-1:0] dp_w_q;
    logic signed [I_BW-1:0] dp_psum_q;
    logic signed [O_BW-1:0] y_q;
    logic                   valid_q;

    logic                   wr_en;
    logic [IDX_W-1:0]       rd_addr;
    logic signed [X_BW-1:0] rd_x;
    logic signed [W_BW-1:0] rd_w;

    // Buffer write on each LOAD handshake; an abort in the same cycle wins.
    always_comb begin
        wr_en = (state_q == StLoad) && bus.i_xw_valid && !bus.i_clear;
    end

    // Read one tap ahead of the drive registers: tap 0 while loading, then rd_idx+1.
    always_comb begin
        rd_addr = '0;
        if (state_q == StIssue && rd_idx_q != LastIdx) begin
            rd_addr = rd_idx_q + 1'b1;
        end
    end

    conv3x3_tap_buf #(
        .X_BW (X_BW),
        .W_BW (W_BW)
    ) u_tap_buf (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .wr_en_i  (wr_en),
        .wr_idx_i (wr_idx_q),
        .wr_x_i   (bus.i_x),
        .wr_w_i   (bus.i_w),
        .rd_idx_i (rd_addr),
        .rd_x_o   (rd_x),
        .rd_w_o   (rd_w)
    );

    // Job FSM with counters and registered datapath/result drives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            lat_q     <= '0;
            psum_q    <= '0;
            dp_x_q    <= '0;
            dp_w_q    <= '0;
            dp_psum_q <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
        end else if (bus.i_clear) begin
            // o_y deliberately keeps its last value across an abort.
            state_q   <= StIdle;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            lat_q     <= '0;
            dp_x_q    <= '0;
            dp_w_q    <= '0;
            dp_psum_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        psum_q   <= bus.i_psum;
                        wr_idx_q <= '0;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    if (bus.i_xw_valid) begin
                        if (wr_idx_q == LastIdx) begin
                            // Tap 0 goes out on the cycle right after the last acceptance.
                            wr_idx_q  <= '0;
                            rd_idx_q  <= '0;
                            dp_x_q    <= rd_x;
                            dp_w_q    <= rd_w;
                            dp_psum_q <= psum_q;
                            state_q   <= StIssue;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_q <= '0;
                        lat_q    <= '0;
                        dp_x_q   <= '0;
                        dp_w_q   <= '0;
                        state_q  <= StDrain;
                    end else begin
                        rd_idx_q <= rd_idx_q + 1'b1;
                        dp_x_q   <= rd_x;
                        dp_w_q   <= rd_w;
                    end
                end
                StDrain: begin
                    if (lat_q == LastLat) begin
                        lat_q     <= '0;
                        y_q       <= bus.i_dp_y;
                        valid_q   <= 1'b1;
                        dp_psum_q <= '0;
                        state_q   <= StDone;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_xw_ready = (state_q == StLoad);
    assign bus.o_busy     = (state_q != StIdle);
    assign bus.o_dp_x     = dp_x_q;
    assign bus.o_dp_w     = dp_w_q;
    assign bus.o_dp_psum  = dp_psum_q;
    assign bus.o_y        = y_q;
    assign bus.o_valid    = valid_q;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Bench for conv3x3_ctrl: directed and random windows against a sliding-window
// MAC datapath model and a psum + sum(x*w) result reference.
module tb_conv3x3_ctrl;

    localparam int unsigned X_BW = 8;
    localparam int unsigned W_BW = 8;
    localparam int unsigned I_BW = 19;
    localparam int unsigned O_BW = 19;
    localparam int unsigned TAPS = 9;
    localparam int unsigned LAT  = 27;

    logic clk;
    logic rst;
    int   cyc_n;
    int   n_checks;
    int   n_bad;

    longint tx [TAPS];
    longint tw [TAPS];
    longint psum_v;

    typedef struct {
        longint x;
        longint w;
        longint p;
    } tap_s;

    tap_s   hist[$];
    longint acc_m;

    conv3x3_ctrl_if #(
        .X_BW (X_BW),
        .W_BW (W_BW),
        .I_BW (I_BW),
        .O_BW (O_BW)
    ) bus ();

    conv3x3_ctrl #(
        .X_BW (X_BW),
        .W_BW (W_BW),
        .I_BW (I_BW),
        .O_BW (O_BW),
        .TAPS (TAPS),
        .LAT  (LAT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Datapath model: y in cycle t = psum(t-LAT) + sum of x*w over cycles t-LAT-8 .. t-LAT.
    always @(negedge clk) begin
        hist.push_back('{x: longint'(bus.o_dp_x), w: longint'(bus.o_dp_w),
                         p: longint'(bus.o_dp_psum)});
        if (hist.size() > LAT + TAPS) void'(hist.pop_front());
        acc_m = 0;
        if (hist.size() == LAT + TAPS) begin
            acc_m = hist[TAPS-1].p;
            for (int j = 0; j < TAPS; j++) acc_m += hist[j].x * hist[j].w;
        end
        bus.i_dp_y = O_BW'(acc_m);
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic longint exp_y();
        longint s = psum_v;
        for (int k = 0; k < TAPS; k++) s += tx[k] * tw[k];
        return s;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, longint'(bus.o_busy), 0);
        check_eq({tag, "_valid"}, longint'(bus.o_valid), 0);
        check_eq({tag, "_ready"}, longint'(bus.o_xw_ready), 0);
        check_eq({tag, "_dp"}, longint'({bus.o_dp_x, bus.o_dp_w, bus.o_dp_psum}), 0);
    endtask

    task automatic start_job();
        check_eq("idle_before_start", longint'(bus.o_busy), 0);
        bus.i_start = 1'b1;
        bus.i_psum  = I_BW'(psum_v);
        cyc();
        bus.i_start = 1'b0;
        bus.i_psum  = I_BW'($urandom);
    endtask

    // Offer n pairs with gap idle cycles before each; a = cycle of the last acceptance.
    task automatic feed(input int n, input int gap, output int a);
        int t;
        a = -1;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.i_xw_valid = 1'b0;
                bus.i_x = X_BW'($urandom);
                bus.i_w = W_BW'($urandom);
                cyc();
            end
            bus.i_xw_valid = 1'b1;
            bus.i_x = X_BW'(tx[i]);
            bus.i_w = W_BW'(tw[i]);
            t = 0;
            while (!bus.o_xw_ready && t < 50) begin
                cyc();
                t++;
            end
            if (!bus.o_xw_ready) begin
                check_eq("xw_ready_timeout", 0, 1);
                bus.i_xw_valid = 1'b0;
                return;
            end
            a = cyc_n;
            cyc();
        end
        bus.i_xw_valid = 1'b0;
    endtask

    // Called in cycle a+1: taps 0..8 must appear on nine consecutive cycles.
    task automatic check_issue(input int a);
        check_eq("issue_start_cycle", cyc_n, a + 1);
        for (int k = 0; k < TAPS; k++) begin
            check_eq("tap_x", longint'(bus.o_dp_x), tx[k]);
            check_eq("tap_w", longint'(bus.o_dp_w), tw[k]);
            check_eq("tap_psum", longint'(bus.o_dp_psum), psum_v);
            cyc();
        end
        check_eq("drain_x0", longint'({bus.o_dp_x, bus.o_dp_w}), 0);
        check_eq("drain_psum_held", longint'(bus.o_dp_psum), psum_v);
    endtask

    task automatic wait_result(input int a, input longint exp);
        int t = 0;
        while (!bus.o_valid && t < LAT + 40) begin
            cyc();
            t++;
        end
        check_eq("valid_cycle", cyc_n, a + 10 + LAT);
        check_eq("result_y", longint'(bus.o_y), exp);
        check_eq("done_dp_zero", longint'({bus.o_dp_x, bus.o_dp_w, bus.o_dp_psum}), 0);
    endtask

    // Hold i_ready low for hold cycles (with a stray start), then hand the result off.
    task automatic finish_job(input int hold);
        longint y0 = longint'(bus.o_y);
        for (int i = 0; i < hold; i++) begin
            bus.i_start = (i == hold / 2);
            check_eq("hold_valid", longint'(bus.o_valid), 1);
            check_eq("hold_y", longint'(bus.o_y), y0);
            cyc();
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        cyc();
        bus.i_ready = 1'b0;
        check_eq("after_hs_valid", longint'(bus.o_valid), 0);
        check_eq("after_hs_busy", longint'(bus.o_busy), 0);
        cyc();
        check_eq("one_result_busy", longint'(bus.o_busy), 0);
    endtask

    task automatic run_job(input int gap, input int hold);
        int a;
        start_job();
        feed(TAPS, gap, a);
        check_issue(a);
        wait_result(a, exp_y());
        finish_job(hold);
    endtask

    task automatic set_uniform(input longint p, input longint x, input longint w);
        psum_v = p;
        for (int k = 0; k < TAPS; k++) begin
            tx[k] = x;
            tw[k] = w;
        end
    endtask

    task automatic set_nominal();
        set_uniform(100, 10, 5);
        tx[0] = 100;
        tw[0] = 50;
    endtask

    initial begin
        int a;
        longint y_prev;
        n_checks = 0;
        n_bad    = 0;
        cyc_n    = 0;
        rst      = 1'b1;
        bus.i_clear    = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_psum     = '0;
        bus.i_x        = '0;
        bus.i_w        = '0;
        bus.i_xw_valid = 1'b0;
        bus.i_ready    = 1'b0;
        repeat (3) cyc();
        check_quiet("reset");
        check_eq("reset_y", longint'(bus.o_y), 0);
        rst = 1'b0;
        cyc();
        check_quiet("post_reset");

        // Nominal window.
        set_nominal();
        check_eq("nominal_ref", exp_y(), 5500);
        run_job(0, 0);

        // Signed extremes.
        set_uniform(0, -128, -128);
        run_job(0, 1);
        check_eq("ext_pos_y", longint'(bus.o_y), 147456);
        set_uniform(-1000, -128, 127);
        run_job(0, 0);
        check_eq("ext_neg_y", longint'(bus.o_y), -147304);

        // Feeder stalls: same result as unstalled.
        set_nominal();
        run_job(3, 0);
        check_eq("stall_y", longint'(bus.o_y), 5500);

        // Consumer backpressure.
        set_uniform(-7, 3, -9);
        run_job(0, 20);

        // Abort mid-LOAD, with start and a valid pair in the same cycle.
        y_prev = longint'(bus.o_y);
        set_nominal();
        start_job();
        feed(4, 0, a);
        bus.i_clear = 1'b1;
        bus.i_start = 1'b1;
        bus.i_xw_valid = 1'b1;
        cyc();
        bus.i_clear = 1'b0;
        bus.i_start = 1'b0;
        bus.i_xw_valid = 1'b0;
        check_quiet("clr_load");
        check_eq("clr_load_y_kept", longint'(bus.o_y), y_prev);

        // Abort mid-DRAIN.
        start_job();
        feed(TAPS, 0, a);
        check_issue(a);
        repeat (10) cyc();
        check_eq("drain_busy", longint'(bus.o_busy), 1);
        bus.i_clear = 1'b1;
        cyc();
        bus.i_clear = 1'b0;
        check_quiet("clr_drain");
        check_eq("clr_drain_y_kept", longint'(bus.o_y), y_prev);
        repeat (LAT + 5) cyc();
        check_quiet("clr_drain_late");

        // Job after aborts.
        set_uniform(12345, 77, -33);
        run_job(1, 2);

        // Async reset between edges during ISSUE.
        set_uniform(500, 60, 70);
        start_job();
        feed(TAPS, 0, a);
        cyc();
        cyc();
        check_eq("pre_rst_busy", longint'(bus.o_busy), 1);
        #2 rst = 1'b1;
        #1;
        check_quiet("async_rst");
        check_eq("async_rst_y", longint'(bus.o_y), 0);
        cyc();
        rst = 1'b0;
        cyc();
        set_nominal();
        run_job(0, 0);

        // Random windows with random stalls and backpressure.
        for (int r = 0; r < 8; r++) begin
            psum_v = longint'($urandom_range(200000)) - 100000;
            for (int k = 0; k < TAPS; k++) begin
                tx[k] = longint'($urandom_range(255)) - 128;
                tw[k] = longint'($urandom_range(255)) - 128;
            end
            run_job(int'($urandom_range(2)), int'($urandom_range(5)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_ctrl.md
# conv3x3_ctrl

Sequencing controller for the `convolution_3x3` MAC datapath.
- Buffers one 3x3 window of (x, w) pairs from a valid/ready feeder and captures the partial-sum input at job start.
- Replays the nine taps to the datapath on nine back-to-back cycles, waits out the pipeline latency, then samples the datapath result.
- Presents the result on a valid/ready output.
- Sits between the window/weight fetch logic and the datapath. The datapath has no enable, so gap-free tap delivery is this block's responsibility.

## Interface
- `X_BW`, 8, signed activation width
- `W_BW`, 8, signed weight width
- `I_BW`, 19, signed partial-sum width
- `O_BW`, 19, signed result width
- `TAPS`, 9, taps per window; fixed at 9 for this datapath
- `LAT`, 27, cycles from the last tap presented to the datapath until `i_dp_y` holds the result; must match the datapath build

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_clear`  in  1  synchronous abort, returns to IDLE
- `i_start`  in  1  job start pulse
- `i_psum`  in  I_BW  partial sum, captured with `i_start`
- `i_x`, `i_w`  in  X_BW / W_BW  tap pair from feeder
- `i_xw_valid`  in  1  tap pair valid
- `o_xw_ready`  out  1  tap pair accepted when high with valid
- `o_dp_x`, `o_dp_w`, `o_dp_psum`  out  X_BW / W_BW / I_BW  registered drive to datapath `i_x`, `i_w`, `i_psum`
- `i_dp_y`  in  O_BW  datapath `o_y`
- `o_y`  out  O_BW  captured result
- `o_valid`  out  1  result valid
- `i_ready`  in  1  result consumer ready
- `o_busy`  out  1  high in every state except IDLE

## Operation
States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- **IDLE:** `o_xw_ready`=0. When `i_start`=1, capture `i_psum` and go to LOAD. `i_start` is ignored in every other state.
- **LOAD:** `o_xw_ready`=1. Each valid&ready handshake writes the pair to buffer entry `wr_idx` (0..8). On the 9th acceptance, go to ISSUE. The feeder may stall arbitrarily; gaps are absorbed here.
- **ISSUE:** runs exactly TAPS cycles, `rd_idx` 0..8. Drives `o_dp_x`/`o_dp_w` from `buf[rd_idx]` and `o_dp_psum` from the captured psum. `o_xw_ready`=0. After `rd_idx`=8, go to DRAIN.
- **DRAIN:** counts LAT cycles with `o_dp_x`/`o_dp_w`=0 and `o_dp_psum` held. On the final count, register `i_dp_y` into `o_y` and go to DONE.
- **DONE:** `o_valid`=1 and `o_y` stable. When `o_valid & i_ready`, go to IDLE. The next job may start on the following cycle.
- `o_dp_x`, `o_dp_w` and `o_dp_psum` are 0 in IDLE, LOAD, DONE, and on the cycle after any abort.
- No arithmetic in this block. Values pass through unmodified at their full declared widths, with no sign extension or truncation.
- `i_clear` (any state) returns to IDLE next cycle. It zeroes counters, `o_valid` and datapath drives; `o_y` keeps its last value. `i_clear` has priority over `i_start` and over any handshake in the same cycle.
- `i_rst` asserted mid-job: immediate return to IDLE, all outputs at reset values.

## Timing
- Reset values:
  - `o_xw_ready`=0, `o_valid`=0, `o_busy`=0
  - `o_y`=0, `o_dp_x`=0, `o_dp_w`=0, `o_dp_psum`=0
  - state IDLE, all counters 0
- `i_start` in cycle c puts the block in LOAD at c+1, so the first pair can be accepted in c+1.
- 9th acceptance in cycle a: tap 0 appears on `o_dp_*` in cycle a+1, tap 8 in a+9.
- `i_dp_y` is sampled in cycle a+9+LAT. `o_valid` rises in a+10+LAT.
- Minimum job time with no stalls: 1 + 9 + 9 + LAT + 1 cycles, plus consumer wait.
- An `o_valid`/`i_ready` handshake in cycle d puts the block in IDLE at d+1, with `o_valid`=0 and `o_busy`=0.
- The ISSUE phase never stalls, and the nine datapath taps are always contiguous.

## Structure
- Package `conv3x3_ctrl_pkg` holds:
  - the state enum
  - `TAPS_C`=9
  - `IDX_W` = clog2(TAPS)
  - `LAT_W` = clog2(LAT+1)
- Sub-module `conv3x3_tap_buf`: 9-entry register file of {x, w} with one write port (`wr_en`, `wr_idx`) and one combinational read port (`rd_idx`).
- FSM, counters and output registers live in the top module.

## Test plan
- **Nominal window:** `i_psum`=100; taps (100,50) then (10,5)×8; bench datapath model y = psum + Σx·w, valid LAT cycles after tap 8. Expect `o_y`=5500 and `o_valid` exactly a+10+LAT.
- **Signed extremes:** `i_psum`=0; taps (-128,-128)×9. Expect `o_y`=147456. Also `i_psum`=-1000 with taps (-128,127)×9: expect `o_y`=-147304.
- **Feeder stalls:** `i_xw_valid` low for 3 cycles between each pair. `o_dp_*` must still show taps 0..8 on 9 consecutive cycles, and the result must equal the unstalled run.
- **Consumer backpressure:** hold `i_ready`=0 for 20 cycles. `o_valid` and `o_y` stay stable, a repeated `i_start` is ignored, and there is exactly one result per start.
- **Abort:** `i_clear` in mid-LOAD (after 4 taps) and again in mid-DRAIN. Next cycle: IDLE, `o_busy`=0, `o_dp_*`=0, no `o_valid`. The following job computes correctly.
- **Async reset:** assert `i_rst` between clock edges during ISSUE. All outputs go to reset values immediately; a clean job runs after release.
